// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM states, channel and counter
// widths, and the x4 count scaling also used by the sample FIFO counters.
package la_pkg;

  localparam int CHANNELS = 8;
  localparam int CNT_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } la_state_e;

  // Sample counts are programmed in units of four samples.
  function automatic logic [CNT_W-1:0] scale_count(input logic [7:0] count);
    return {count, 2'b00};
  endfunction

endpackage

// File: rtl/sample_clock_div.sv
// Sample-clock divider: counts 0..clk_div and strobes on the terminal count.
// A clear restarts the count so the first strobe lands clk_div+1 cycles later.
module sample_clock_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] clk_div,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Terminal-count strobe and next count value.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    strobe = (cnt_q == clk_div);
    cnt_d  = strobe ? '0 : cnt_q + DIV_W'(1);
    if (clear) begin
      cnt_d = '0;
    end
  end

  // Divider count register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trigger_sampler.sv
// Logic-analyzer capture front end: synchronizes the probes, strobes them at
// the divided sample rate and runs the pre / armed / post capture sequence,
// handing one byte per emitting strobe to the sample FIFO.
module trigger_sampler #(
  parameter int CHANNELS = la_pkg::CHANNELS,
  parameter int DIV_W    = 16,
  parameter int CNT_W    = la_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] probe_in,
  input  logic                arm,
  input  logic                abort,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic [CHANNELS-1:0] trig_mask,
  input  logic [CHANNELS-1:0] trig_value,
  input  logic [CHANNELS-1:0] trig_edge,
  input  logic [7:0]          pre_count,
  input  logic [7:0]          post_count,
  input  logic                fifo_full,
  output logic                sample_valid,
  output logic [CHANNELS-1:0] sample_data,
  output logic [2:0]          state,
  output logic                triggered,
  output logic                done,
  output logic                overrun
);

  import la_pkg::*;

  la_state_e           state_q, state_d;
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic [CHANNELS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0]    post_q, post_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] value_q, value_d;
  logic [CHANNELS-1:0] edge_q, edge_d;
  logic                trig_q, trig_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic                strobe;
  logic                arm_accept;
  logic                emit;
  logic [CHANNELS-1:0] chan_hit;
  logic                trig_hit;

  sample_clock_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .clear   (arm_accept),
    .clk_div (clk_div),
    .strobe  (strobe)
  );

  // Trigger compare on the sample being strobed: unmasked channels always
  // pass, edge channels additionally need the previous sample off-value.
  always_comb begin
    chan_hit = ~mask_q | (~(sync2_q ^ value_q) & (~edge_q | (prev_q ^ value_q)));
    trig_hit = &chan_hit;
  end

  // Every strobe captures the synchronized probes, whatever the state.
  always_comb begin
    data_d = strobe ? sync2_q : data_q;
    prev_d = strobe ? sync2_q : prev_q;
  end

  // Capture sequencer: config latch on arm, per-strobe emission, counters,
  // trigger decision and sticky status flags.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    post_d     = post_q;
    mask_d     = mask_q;
    value_d    = value_q;
    edge_d     = edge_q;
    trig_d     = trig_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    valid_d    = 1'b0;
    arm_accept = 1'b0;
    emit       = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            arm_accept = 1'b1;
            pre_d      = CNT_W'(scale_count(pre_count));
            post_d     = CNT_W'(scale_count(post_count));
            mask_d     = trig_mask;
            value_d    = trig_value;
            edge_d     = trig_edge;
            trig_d     = 1'b0;
            done_d     = 1'b0;
            ovr_d      = 1'b0;
            state_d    = (pre_count == 8'd0) ? ST_ARMED : ST_PRE;
          end
        end
        ST_PRE: begin
          if (strobe) begin
            emit = 1'b1;
            if (pre_q != '0) begin
              pre_d = pre_q - CNT_W'(1);
            end
            if (pre_d == '0) begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (strobe) begin
            emit = 1'b1;
            if (trig_hit) begin
              trig_d = 1'b1;
              if (post_q == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (strobe) begin
            emit = 1'b1;
            if (post_q != '0) begin
              post_d = post_q - CNT_W'(1);
            end
            if (post_d == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A full FIFO drops the byte but the capture keeps real-time pace.
      if (emit) begin
        if (fifo_full) begin
          ovr_d = 1'b1;
        end else begin
          valid_d = 1'b1;
        end
      end
    end
  end

  // Synchronizer, sample path and sequencer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pre_q   <= '0;
      post_q  <= '0;
      mask_q  <= '0;
      value_q <= '0;
      edge_q  <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= probe_in;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pre_q   <= pre_d;
      post_q  <= post_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      edge_q  <= edge_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign state        = state_q;
  assign triggered    = trig_q;
  assign done         = done_q;
  assign overrun      = ovr_q;

endmodule

// File: doc/trigger_sampler.md
Name: trigger_sampler

Overview:
Capture front end of the logic analyzer, directly upstream of the sample FIFO. Synchronizes the 8 probe channels and divides the system clock into a sample strobe. Runs a pre-trigger / armed / post-trigger capture sequence on a level/edge trigger and emits one byte per strobe to the FIFO as a `data_valid`/`data_in` pulse pair. Pre/post counts use the same ×4 scaling as the FIFO counters: register value = {count, 2'b00}.

Parameters:
CHANNELS, 8, probe width and sample byte width
DIV_W, 16, width of sample-clock divider
CNT_W, 10, width of internal pre/post counters (8-bit count ×4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
probe_in  in  CHANNELS  raw asynchronous probe pins
arm  in  1  single-cycle pulse: latch config, start capture
abort  in  1  single-cycle pulse: return to IDLE
clk_div  in  DIV_W  sample period minus 1, in clk cycles
trig_mask  in  CHANNELS  1 = channel participates in trigger
trig_value  in  CHANNELS  required level or post-edge level
trig_edge  in  CHANNELS  1 = edge condition, 0 = level condition
pre_count  in  8  pre-trigger samples / 4
post_count  in  8  post-trigger samples / 4
fifo_full  in  1  downstream FIFO full
sample_valid  out  1  one-cycle pulse, sample_data valid
sample_data  out  CHANNELS  captured sample
state  out  3  current FSM state
triggered  out  1  sticky, trigger seen this capture
done  out  1  sticky, capture complete
overrun  out  1  sticky, sample dropped on fifo_full

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, state = IDLE, divider and counters 0, sync flops 0.
- Probe path: 2-flop synchronizer. `prev` register holds the last strobed sample for edge detection.
- Divider: counts 0..clk_div and strobes on the cycle it equals clk_div, then wraps to 0. It is cleared on an accepted arm. Timing: clk_div=0 strobes every cycle; arm accepted at cycle 0 with clk_div=N gives the first strobe at cycle N+1.
- Strobe behaviour: a strobe at cycle t latches the synchronizer output into sample_data. If the current state emits samples, sample_valid is high at t+1 for exactly one cycle.
- FSM states: IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.
  - IDLE/DONE + arm: latch pre={pre_count,00}, post={post_count,00}, and the trigger masks/values/edges. Clear triggered/done/overrun. Go to PRE, or to ARMED if pre=0.
  - PRE: emit every strobe and decrement pre. Move to ARMED after the emitting strobe that takes pre to 0. No trigger evaluation in PRE.
  - ARMED: emit every strobe and evaluate the trigger on that strobe's sample.
    - Per masked channel i: level requires s[i]==value[i]. Edge requires s[i]==value[i] && prev[i]!=value[i].
    - All masked channels must match (AND). Mask=0 triggers on the first ARMED strobe.
    - On match: triggered=1 and the trigger sample is emitted. Go to POST, or to DONE if post=0.
  - POST: emit every strobe and decrement post. Move to DONE after post reaches 0; done=1.
  - DONE: no emission, holds until arm.
- arm in PRE/ARMED/POST is ignored.
- abort in any state: IDLE next cycle, with no sample_valid that cycle. Sticky flags are retained. abort wins over simultaneous arm.
- Overrun:
  - A strobe that would emit while fifo_full=1 raises no sample_valid and sets overrun=1.
  - Counters and trigger evaluation still advance, so capture timing stays real-time.
- Arithmetic: counters are CNT_W unsigned, always loaded ≤1020, decrement only when nonzero. There is no wrap.

Decomposition:
- Shared package la_pkg: state enum typedef, CHANNELS, CNT_W, and the ×4 count-scaling constant/function, shared with the FIFO.
- One sub-module: sample_clock_div (divider plus strobe, with clear input).
- Synchronizer, trigger compare and FSM stay in trigger_sampler.

Test Plan:
1. Full level-trigger capture:
   - Setup: clk_div=0, pre=1, post=1, mask=0x01, value=0x01, edge=0; probe=0x00, arm; probe→0x01 after 10 strobes.
   - Required: 4 PRE samples, then ARMED samples until the trigger; trigger sample 0x01; 4 POST samples; done=1, state=4.
2. Rising-edge trigger:
   - Setup: mask=0x08, value=0x08, edge=0x08; probe ch3 high at arm.
   - Required: no trigger while ch3 stays high. Ch3 low then high → trigger on the first strobe seeing the high level.
3. Divider timing: clk_div=3, pre=0, mask=0, arm at cycle 0 → strobe at cycle 4, sample_valid at cycle 5, triggered=1, state=DONE after post=0.
4. Overrun:
   - Setup: post=1; fifo_full=1 for 2 POST strobes.
   - Required: 2 sample_valid pulses missing, overrun=1, done still after the 4th post-trigger strobe.
5. Abort:
   - Abort in POST → state=IDLE next cycle, no further sample_valid, done=0.
   - Arm and abort in the same cycle from IDLE → remains IDLE.
6. Reset mid-capture: reset asserted asynchronously in ARMED → state=0 and all outputs 0 before the next clk edge. A subsequent arm starts a clean capture.
